// File: rtl/srl_fifo.sv
// Small synchronous FIFO on an addressable shift-register store (SRL-style).
// Define SRL_FIFO_PROG_FULL_EN to add the registered prog_full flag.
module srl_fifo #(
  parameter int unsigned WIDTH            = 8,
  parameter int unsigned DEPTH            = 16,
  parameter int unsigned PROG_FULL_THRESH = 12
) (
  input  logic                         CLK,
  input  logic                         RSTN,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
`ifdef SRL_FIFO_PROG_FULL_EN
  output logic                         prog_full,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [WIDTH-1:0] r_sr [DEPTH];
  logic [CW-1:0]    r_count;
  logic [AW-1:0]    r_addr;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_count_d;
  logic [AW-1:0]    w_addr_d;

  assign w_full  = (r_count == FullCount);
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid & ~w_full;
  assign w_pop   = out_ready & ~w_empty;

  always_comb begin
    w_count_d = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + CW'(1);
      2'b01:   w_count_d = r_count - CW'(1);
      default: w_count_d = r_count;
    endcase
  end

  // Read address tracks count-1 so the output mux is driven straight from a register.
  always_comb begin
    w_addr_d = '0;
    if (w_count_d != '0) begin
      w_addr_d = AW'(w_count_d - CW'(1));
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_count <= '0;
      r_addr  <= '0;
    end else begin
      r_count <= w_count_d;
      r_addr  <= w_addr_d;
    end
  end

  // No reset on the array so it can map onto LUT shift registers.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_sr[0] <= in_data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign out_data  = r_sr[r_addr];
  assign out_valid = ~w_empty;
  assign in_ready  = ~w_full;
  assign count     = r_count;

`ifdef SRL_FIFO_PROG_FULL_EN
  logic r_prog_full;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_prog_full <= 1'b0;
    end else begin
      r_prog_full <= (w_count_d >= CW'(PROG_FULL_THRESH));
    end
  end

  assign prog_full = r_prog_full;
`else
  logic w_unused_thresh;
  assign w_unused_thresh = ^PROG_FULL_THRESH;
`endif

  // A stalled write must be held with unchanged data until accepted.
  a_sender_stable: assert property (@(posedge CLK) disable iff (!RSTN)
    (in_valid && !in_ready) |=> (in_valid && $stable(in_data)));

endmodule

// File: tb/tb_srl_fifo.sv
// Randomised scoreboard bench for srl_fifo: a queue model predicts every pop and all flags.
module tb_srl_fifo;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned THRESH = 12;
  localparam int unsigned CW     = $clog2(DEPTH + 1);

  logic             CLK = 1'b0;
  logic             RSTN = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CW-1:0]    count;
`ifdef SRL_FIFO_PROG_FULL_EN
  logic             prog_full;
`endif

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q[$];
  bit               stalled = 1'b0;

  srl_fifo #(
    .WIDTH            (WIDTH),
    .DEPTH            (DEPTH),
    .PROG_FULL_THRESH (THRESH)
  ) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SRL_FIFO_PROG_FULL_EN
    .prog_full (prog_full),
`endif
    .count     (count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: mid-cycle, inputs and outputs are settled; predict the coming edge.
  always @(negedge CLK) begin
    int sz;
    if (!RSTN) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      sz = exp_q.size();
      chk("count", 64'(count), 64'(sz));
      chk("in_ready", 64'(in_ready), 64'(sz < DEPTH));
      chk("out_valid", 64'(out_valid), 64'(sz > 0));
`ifdef SRL_FIFO_PROG_FULL_EN
      chk("prog_full", 64'(prog_full), 64'(sz >= THRESH));
`endif
      if (out_ready && sz > 0) begin
        chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
      end
      stalled = in_valid && (sz >= DEPTH);
      if (in_valid && sz < DEPTH) exp_q.push_back(in_data);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH && exp_q.size() > 0; i++) step();
    out_ready = 1'b0;
    chk(name, 64'(out_valid), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    step();
    RSTN = 1'b1;
    step();

    // Fill 0x01..0x10 with consumer stalled
    in_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_data = WIDTH'(i);
      step();
      chk("fill_count", 64'(count), 64'(i));
    end
    chk("full_in_ready", 64'(in_ready), 64'(0));
    in_data = 8'h11;
    step();
    step();
    chk("full_hold_count", 64'(count), 64'(16));

    // Full with in_valid and out_ready: pop only, then the held word goes in
    out_ready = 1'b1;
    step();
    chk("full_pop_only", 64'(count), 64'(15));
    out_ready = 1'b0;
    step();
    chk("held_word_accepted", 64'(count), 64'(16));
    in_valid = 1'b0;
    chk("oldest_after_full", 64'(out_data), 64'h02);
    drain("drain_empty");
    chk("drain_count", 64'(count), 64'(0));

    // Steady state at occupancy 5
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = WIDTH'(8'h40 + i);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = WIDTH'(8'h45 + i);
      step();
    end
    chk("steady_count", 64'(count), 64'(5));
    in_valid = 1'b0;
    drain("steady_drain");

    // Asynchronous reset mid-cycle
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = WIDTH'(8'h70 + i);
      step();
    end
    in_valid = 1'b0;
    #2;
    RSTN = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'(0));
    chk("async_rst_out_valid", 64'(out_valid), 64'(0));
    chk("async_rst_in_ready", 64'(in_ready), 64'(1));
    step();
    step();
    RSTN = 1'b1;
    step();
    in_valid = 1'b1;
    in_data = 8'hAA;
    step();
    in_valid = 1'b0;
    chk("post_rst_valid", 64'(out_valid), 64'(1));
    chk("post_rst_data", 64'(out_data), 64'hAA);
    drain("post_rst_drain");

    // Random traffic in phases biased toward full, balanced and empty
    for (int ph = 0; ph < 6; ph++) begin
      int pv, pr;
      pv = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 50 : 20;
      pr = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 50 : 85;
      for (int i = 0; i < 300; i++) begin
        if (!stalled) begin
          in_valid = ($urandom_range(99) < pv);
          in_data  = WIDTH'($urandom);
        end
        out_ready = ($urandom_range(99) < pr);
        step();
      end
    end
    while (stalled) begin
      out_ready = 1'b1;
      step();
    end
    in_valid = 1'b0;
    drain("final_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
